// File: rtl/regfile_writeback_queue.sv
// Write-back merge stage: single-cycle ALU results take priority over loads,
// which are buffered in a small FIFO. Also reports pending-write hazards.
module regfile_writeback_queue #(
    parameter int unsigned Data_WIDTH = 32,
    parameter int unsigned Addr_WIDTH = 5,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DROP_R0    = 1
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          AluValid,
    input  logic [Addr_WIDTH-1:0]         AluAddr,
    input  logic [Data_WIDTH-1:0]         AluData,
    input  logic                          LdValid,
    input  logic [Addr_WIDTH-1:0]         LdAddr,
    input  logic [Data_WIDTH-1:0]         LdData,
    output logic                          LdReady,
    output logic                          WriteEn,
    output logic [Addr_WIDTH-1:0]         WriteAddr,
    output logic [Data_WIDTH-1:0]         data_o,
    input  logic [Addr_WIDTH-1:0]         ChkAddr,
    output logic                          ChkHit,
    output logic [$clog2(DEPTH):0]        Count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam bit          DROP  = (DROP_R0 != 0);

    logic [Addr_WIDTH-1:0] fifo_addr [DEPTH];
    logic [Data_WIDTH-1:0] fifo_data [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;

    logic alu_eff;
    logic push;
    logic pop;
    logic fifo_hit;
    logic [PTR_W-1:0] offset;

    // Request decode; space is judged on the registered Count only.
    always_comb begin
        alu_eff = AluValid && !(DROP && (AluAddr == '0));
        LdReady = !Rst && (Count != CNT_W'(DEPTH));
        push    = LdValid && LdReady && !(DROP && (LdAddr == '0));
        pop     = !Rst && !alu_eff && (Count != '0);
    end

    // Hazard lookup over occupied FIFO slots plus the output register.
    always_comb begin
        fifo_hit = 1'b0;
        offset   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(offset) < Count) && (fifo_addr[i] == ChkAddr)) begin
                fifo_hit = 1'b1;
            end
        end
        ChkHit = !Rst && !(DROP && (ChkAddr == '0))
                 && (fifo_hit || (WriteEn && (WriteAddr == ChkAddr)));
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= LdAddr;
            fifo_data[wr_ptr] <= LdData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            Count     <= '0;
            WriteEn   <= 1'b0;
            WriteAddr <= '0;
            data_o    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                Count <= Count + CNT_W'(1);
            end else if (pop && !push) begin
                Count <= Count - CNT_W'(1);
            end

            if (alu_eff) begin
                WriteEn   <= 1'b1;
                WriteAddr <= AluAddr;
                data_o    <= AluData;
            end else if (pop) begin
                WriteEn   <= 1'b1;
                WriteAddr <= fifo_addr[rd_ptr];
                data_o    <= fifo_data[rd_ptr];
            end else begin
                WriteEn   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed bench for regfile_writeback_queue with hand-computed expectations.
module tb_regfile_writeback_queue;

    logic        Clk;
    logic        Rst;
    logic        AluValid;
    logic [4:0]  AluAddr;
    logic [31:0] AluData;
    logic        LdValid;
    logic [4:0]  LdAddr;
    logic [31:0] LdData;
    logic        LdReady;
    logic        WriteEn;
    logic [4:0]  WriteAddr;
    logic [31:0] data_o;
    logic [4:0]  ChkAddr;
    logic        ChkHit;
    logic [2:0]  Count;

    int n_cmp = 0;
    int n_err = 0;

    regfile_writeback_queue #(
        .Data_WIDTH(32), .Addr_WIDTH(5), .DEPTH(4), .DROP_R0(1)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData),
        .LdValid(LdValid), .LdAddr(LdAddr), .LdData(LdData), .LdReady(LdReady),
        .WriteEn(WriteEn), .WriteAddr(WriteAddr), .data_o(data_o),
        .ChkAddr(ChkAddr), .ChkHit(ChkHit), .Count(Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst = 1'b1; AluValid = 1'b0; AluAddr = '0; AluData = '0;
        LdValid = 1'b1; LdAddr = 5'd3; LdData = 32'hAAAA_0003; ChkAddr = 5'd3;

        // Reset with a load offered
        step(); step();
        check("rst_we", WriteEn, 0);
        check("rst_wa", WriteAddr, 0);
        check("rst_data", data_o, 0);
        check("rst_count", Count, 0);
        check("rst_ready", LdReady, 0);
        check("rst_hit", ChkHit, 0);
        Rst = 1'b0; LdValid = 1'b0;
        #1;
        check("rel_ready", LdReady, 1);
        check("rel_count", Count, 0);

        // ALU path
        AluValid = 1'b1; AluAddr = 5'd5; AluData = 32'hDEAD_BEEF;
        step();
        AluValid = 1'b0;
        check("alu_we", WriteEn, 1);
        check("alu_wa", WriteAddr, 5);
        check("alu_data", data_o, 32'hDEAD_BEEF);
        step();
        check("alu_we_off", WriteEn, 0);
        check("alu_wa_hold", WriteAddr, 5);

        // Load path, idle ALU
        LdValid = 1'b1; LdAddr = 5'd7; LdData = 32'h1234_5678;
        #1;
        check("ld_ready", LdReady, 1);
        step();
        LdValid = 1'b0;
        check("ld_count1", Count, 1);
        check("ld_we_n", WriteEn, 0);
        step();
        check("ld_we", WriteEn, 1);
        check("ld_wa", WriteAddr, 7);
        check("ld_data", data_o, 32'h1234_5678);
        check("ld_count0", Count, 0);

        // Priority / backpressure: ALU busy, five loads offered
        AluValid = 1'b1; AluAddr = 5'd10; AluData = 32'h0000_00A0;
        LdValid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            LdAddr = 5'(k); LdData = 32'(k * 32'h11);
            step();
        end
        LdAddr = 5'd5; LdData = 32'h55;
        check("bp_count4", Count, 4);
        check("bp_ready0", LdReady, 0);
        check("bp_alu_wa", WriteAddr, 10);
        step();
        check("bp_count_hold", Count, 4);
        check("bp_ready_hold", LdReady, 0);
        AluValid = 1'b0;
        step();
        check("dr1_wa", WriteAddr, 1);
        check("dr1_data", data_o, 32'h11);
        check("dr1_count", Count, 3);
        check("dr1_ready", LdReady, 1);
        step();
        LdValid = 1'b0;
        check("dr2_wa", WriteAddr, 2);
        check("dr2_count", Count, 3);
        step();
        check("dr3_wa", WriteAddr, 3);
        check("dr3_count", Count, 2);
        step();
        check("dr4_wa", WriteAddr, 4);
        check("dr4_data", data_o, 32'h44);
        step();
        check("dr5_wa", WriteAddr, 5);
        check("dr5_data", data_o, 32'h55);
        check("dr5_count", Count, 0);
        step();
        check("dr_idle_we", WriteEn, 0);

        // Hazard check
        ChkAddr = 5'd9;
        #1;
        check("hz_pre", ChkHit, 0);
        AluValid = 1'b1; AluAddr = 5'd10; LdValid = 1'b1; LdAddr = 5'd9; LdData = 32'h99;
        step();
        LdValid = 1'b0;
        check("hz_queued", ChkHit, 1);
        ChkAddr = 5'd3; #1;
        check("hz_other_q", ChkHit, 0);
        ChkAddr = 5'd9;
        step();
        AluValid = 1'b0;
        check("hz_queued2", ChkHit, 1);
        step();
        check("hz_out_wa", WriteAddr, 9);
        check("hz_out", ChkHit, 1);
        ChkAddr = 5'd3; #1;
        check("hz_other_o", ChkHit, 0);
        ChkAddr = 5'd9;
        step();
        check("hz_clear", ChkHit, 0);

        // DROP_R0: ALU to r0 alongside a queued load to r4
        AluValid = 1'b1; AluAddr = 5'd11; LdValid = 1'b1; LdAddr = 5'd4; LdData = 32'h4444_0004;
        step();
        LdValid = 1'b0;
        check("r0_q_count", Count, 1);
        AluAddr = 5'd0; AluData = 32'h0000_0BAD;
        step();
        AluValid = 1'b0;
        check("r0_we", WriteEn, 1);
        check("r0_wa", WriteAddr, 4);
        check("r0_data", data_o, 32'h4444_0004);
        check("r0_count", Count, 0);
        LdValid = 1'b1; LdAddr = 5'd0; LdData = 32'h0000_0F00;
        ChkAddr = 5'd0;
        #1;
        check("r0_ld_ready", LdReady, 1);
        check("r0_chk", ChkHit, 0);
        step();
        LdValid = 1'b0;
        check("r0_ld_count", Count, 0);
        step();
        check("r0_ld_we", WriteEn, 0);

        // Mid-operation reset discards queued loads
        AluValid = 1'b1; AluAddr = 5'd12; LdValid = 1'b1; LdAddr = 5'd6; LdData = 32'h66;
        step(); step();
        check("mr_count2", Count, 2);
        Rst = 1'b1; AluValid = 1'b0; LdValid = 1'b0;
        step();
        check("mr_count", Count, 0);
        check("mr_we", WriteEn, 0);
        check("mr_wa", WriteAddr, 0);
        Rst = 1'b0;
        step();
        check("mr_no_write", WriteEn, 0);
        check("mr_count_after", Count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
